// File: rtl/miner_tx_pkg.sv
// Shared types and constants for the nonce result transmit path.
// NONCE_RESULT_CHECKSUM_EN selects the 3-word checksummed frame.
package miner_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } tx_state_t;

    localparam logic [7:0]  SYNC_TAG_DEFAULT = 8'hA5;
    localparam logic [31:0] CHK_MASK         = 32'h5A5A5A5A;

`ifdef NONCE_RESULT_CHECKSUM_EN
    localparam int unsigned FRAME_WORDS = 3;
`else
    localparam int unsigned FRAME_WORDS = 2;
`endif

    typedef struct packed {
        logic [7:0]  job_id;
        logic [31:0] nonce;
    } result_entry_t;

endpackage

// File: rtl/nonce_result_tx_if.sv
// Valid/ready word stream carrying result frames toward the host.
interface nonce_result_tx_if #(
    parameter int unsigned WORD_W = 32
) ();
    logic [WORD_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              tx_last;

    modport master (output tx_data, output tx_valid, output tx_last, input tx_ready);
    modport slave  (input tx_data, input tx_valid, input tx_last, output tx_ready);
endinterface

// File: rtl/tx_word_counter.sv
// Word index within the frame being sent; clear on load, advance on handshake.
module tx_word_counter #(
    parameter int unsigned WORDS = 2,
    parameter int unsigned IDX_W = $clog2(WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_last
);
    logic [IDX_W-1:0] r_idx;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_idx <= '0;
        end else if (i_en && !o_last) begin
            r_idx <= r_idx + 1'b1;
        end
    end

    assign o_idx  = r_idx;
    assign o_last = (r_idx == IDX_W'(WORDS - 1));
endmodule

// File: rtl/nonce_result_tx.sv
// Serialises found nonces into fixed result frames on a 32-bit stream.
// Build with NONCE_RESULT_CHECKSUM_EN for a third checksum word per frame.
module nonce_result_tx
    import miner_tx_pkg::*;
#(
    parameter int unsigned WORD_W   = 32,
    parameter int unsigned QDEPTH   = 2,
    parameter logic [7:0]  SYNC_TAG = SYNC_TAG_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     found,
    input  logic [31:0]              found_nonce,
    input  logic [7:0]               job_id,
    nonce_result_tx_if.master        tx,
    output logic                     busy,
    output logic [7:0]               drop_cnt
);
    localparam int unsigned PTR_W = $clog2(QDEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned IDX_W = $clog2(FRAME_WORDS);

    result_entry_t    r_q_mem [QDEPTH];
    logic [PTR_W-1:0] r_head, r_tail;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_d;
    tx_state_t        r_state, w_state_d;
    logic [7:0]       r_job, r_seq, r_drop;
    logic [31:0]      r_nonce;
    logic             w_full, w_pop, w_push, w_drop, w_hs, w_last;
    logic [IDX_W-1:0] w_idx;
    logic [31:0]      w_w0;
    logic [WORD_W-1:0] w_word;

    assign w_full    = (r_count == CNT_W'(QDEPTH));
    assign w_pop     = (r_state == LOAD);
    // A pop in the same cycle frees a slot, so a full queue can still accept.
    assign w_push    = found && (!w_full || w_pop);
    assign w_drop    = found && w_full && !w_pop;
    assign w_count_d = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    assign w_hs      = (r_state == SEND) && tx.tx_ready;

    tx_word_counter #(
        .WORDS (FRAME_WORDS)
    ) u_word_counter (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_pop),
        .i_en   (w_hs),
        .o_idx  (w_idx),
        .o_last (w_last)
    );

    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_q_mem[r_tail] <= '{job_id: job_id, nonce: found_nonce};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_drop  <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + 1'b1;
            if (w_pop)  r_head <= r_head + 1'b1;
            r_count <= w_count_d;
            if (w_drop && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            IDLE:    if (r_count != '0) w_state_d = LOAD;
            LOAD:    w_state_d = SEND;
            SEND:    if (w_hs && w_last) w_state_d = (w_count_d != '0) ? LOAD : IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_job   <= '0;
            r_nonce <= '0;
            r_seq   <= '0;
        end else begin
            r_state <= w_state_d;
            if (w_pop) begin
                r_job   <= r_q_mem[r_head].job_id;
                r_nonce <= r_q_mem[r_head].nonce;
            end
            if (w_hs && w_last) r_seq <= r_seq + 8'd1;
        end
    end

    assign w_w0 = {SYNC_TAG, 8'h00, r_job, r_seq};

    // Word mux reads only frame registers, so data holds steady under backpressure.
    always_comb begin
        w_word = '0;
        if (r_state == SEND) begin
            if (w_idx == '0) begin
                w_word = w_w0;
`ifdef NONCE_RESULT_CHECKSUM_EN
            end else if (w_idx == IDX_W'(1)) begin
                w_word = r_nonce;
            end else begin
                w_word = w_w0 ^ r_nonce ^ CHK_MASK;
`else
            end else begin
                w_word = r_nonce;
`endif
            end
        end
    end

    assign tx.tx_data  = w_word;
    assign tx.tx_valid = (r_state == SEND);
    assign tx.tx_last  = (r_state == SEND) && w_last;
    assign busy        = (r_state != IDLE) || (r_count != '0);
    assign drop_cnt    = r_drop;
endmodule

// File: tb/tb_nonce_result_tx.sv
// Directed table-driven bench for nonce_result_tx plus multi-cycle corner sequences.
module tb_nonce_result_tx;
    import miner_tx_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        found = 1'b0;
    logic [31:0] found_nonce = '0;
    logic [7:0]  job_id = '0;
    logic        busy;
    logic [7:0]  drop_cnt;

    nonce_result_tx_if tx_if ();

    nonce_result_tx dut (
        .clk         (clk),
        .rst         (rst),
        .found       (found),
        .found_nonce (found_nonce),
        .job_id      (job_id),
        .tx          (tx_if),
        .busy        (busy),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        f;
        logic [7:0]  job;
        logic [31:0] nonce;
        logic        rdy;
        logic        ev;
        logic [31:0] ed;
        logic        el;
        logic        eb;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic f, logic [7:0] j, logic [31:0] n, logic r,
                                logic ev, logic [31:0] ed, logic el, logic eb);
        vec_t v;
        v.f = f; v.job = j; v.nonce = n; v.rdy = r;
        v.ev = ev; v.ed = ed; v.el = el; v.eb = eb;
        return v;
    endfunction

    function automatic logic [31:0] w0_of(logic [7:0] j, logic [7:0] s);
        return {8'hA5, 8'h00, j, s};
    endfunction

    function automatic logic [31:0] chk_of(logic [31:0] a, logic [31:0] b);
        return a ^ b ^ 32'h5A5A5A5A;
    endfunction

    task automatic cmp(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Packs {valid, data, last, busy}.
    task automatic check_out(string name, logic ev, logic [31:0] ed, logic el, logic eb);
        cmp(name, {29'd0, tx_if.tx_valid, tx_if.tx_data, tx_if.tx_last, busy},
                  {29'd0, ev, ed, el, eb});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic f, logic [7:0] j, logic [31:0] n, logic r);
        found = f; job_id = j; found_nonce = n; tx_if.tx_ready = r;
    endtask

    task automatic do_reset();
        found = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Waits (bounded) for a frame with ready held high and checks every word.
    task automatic expect_frame(string name, logic [7:0] j, logic [7:0] s, logic [31:0] n);
        int waited = 0;
        logic [31:0] exp_w;
        tx_if.tx_ready = 1'b1;
        @(negedge clk);
        while (!tx_if.tx_valid && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        cmp({name, " start"}, 64'(tx_if.tx_valid), 64'd1);
        if (tx_if.tx_valid) begin
            for (int w = 0; w < int'(FRAME_WORDS); w++) begin
                if (w == 0)      exp_w = w0_of(j, s);
                else if (w == 1) exp_w = n;
                else             exp_w = chk_of(w0_of(j, s), n);
                cmp($sformatf("%s w%0d", name, w),
                    {31'd0, tx_if.tx_valid, tx_if.tx_data, tx_if.tx_last},
                    {31'd0, 1'b1, exp_w, (w == int'(FRAME_WORDS) - 1)});
                @(negedge clk);
            end
            cmp({name, " gap"}, 64'(tx_if.tx_valid), 64'd0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic cs;
        cs = (FRAME_WORDS == 3);

        tx_if.tx_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_out("reset outs", 1'b0, 32'd0, 1'b0, 1'b0);
        cmp("reset drop", 64'(drop_cnt), 64'd0);
        tick();

        // Two back-to-back single results: found+3 latency, seq 0 then 1.
        vecs.push_back(mk(1, 8'h3C, 32'hDEADBEEF, 1, 0, 32'h0, 0, 0));
        vecs.push_back(mk(0, 8'h00, 32'h0, 1, 0, 32'h0, 0, 1));
        vecs.push_back(mk(0, 8'h00, 32'h0, 1, 0, 32'h0, 0, 1));
        vecs.push_back(mk(0, 8'h00, 32'h0, 1, 1, 32'hA5003C00, 0, 1));
        vecs.push_back(mk(0, 8'h00, 32'h0, 1, 1, 32'hDEADBEEF, !cs, 1));
        if (cs) vecs.push_back(mk(0, 8'h00, 32'h0, 1, 1,
                                  chk_of(32'hA5003C00, 32'hDEADBEEF), 1, 1));
        vecs.push_back(mk(1, 8'h01, 32'h12345678, 1, 0, 32'h0, 0, 0));
        vecs.push_back(mk(0, 8'h00, 32'h0, 1, 0, 32'h0, 0, 1));
        vecs.push_back(mk(0, 8'h00, 32'h0, 1, 0, 32'h0, 0, 1));
        vecs.push_back(mk(0, 8'h00, 32'h0, 1, 1, 32'hA5000101, 0, 1));
        vecs.push_back(mk(0, 8'h00, 32'h0, 1, 1, 32'h12345678, !cs, 1));
        if (cs) vecs.push_back(mk(0, 8'h00, 32'h0, 1, 1,
                                  chk_of(32'hA5000101, 32'h12345678), 1, 1));
        vecs.push_back(mk(0, 8'h00, 32'h0, 1, 0, 32'h0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].f, vecs[i].job, vecs[i].nonce, vecs[i].rdy);
            @(negedge clk);
            check_out($sformatf("vec %0d", i), vecs[i].ev, vecs[i].ed, vecs[i].el, vecs[i].eb);
            @(posedge clk);
            #1;
        end

        // Backpressure on W0 for five cycles.
        drive(1, 8'h11, 32'hCAFEF00D, 0);
        tick();
        found = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_out($sformatf("stall %0d", i), 1'b1, w0_of(8'h11, 8'd2), 1'b0, 1'b1);
            @(posedge clk);
            #1;
        end
        expect_frame("bp frame", 8'h11, 8'd2, 32'hCAFEF00D);

        // Overflow: third pulse lands on LOAD with a full queue, fourth is dropped.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, 8'h20 + 8'(i), 32'h10000000 + 32'(i), 0);
            if (i == 3) begin
                @(negedge clk);
                cmp("full+pop drop", 64'(drop_cnt), 64'd0);
                check_out("ovf w0 held", 1'b1, w0_of(8'h20, 8'd0), 1'b0, 1'b1);
            end
            tick();
        end
        found = 1'b0;
        @(negedge clk);
        cmp("ovf drop", 64'(drop_cnt), 64'd1);
        tick();
        tick();
        expect_frame("ovf a", 8'h20, 8'd0, 32'h10000000);
        expect_frame("ovf b", 8'h21, 8'd1, 32'h10000001);
        expect_frame("ovf c", 8'h22, 8'd2, 32'h10000002);
        @(negedge clk);
        check_out("ovf idle", 1'b0, 32'd0, 1'b0, 1'b0);
        cmp("ovf drop kept", 64'(drop_cnt), 64'd1);
        tick();

        // Reset while W1 is on the bus.
        drive(1, 8'h30, 32'h0BADF00D, 1);
        tick();
        found = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check_out("mid w0", 1'b1, w0_of(8'h30, 8'd3), 1'b0, 1'b1);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check_out("mid w1", 1'b1, 32'h0BADF00D, cs ? 1'b0 : 1'b1, 1'b1);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_out("after rst", 1'b0, 32'd0, 1'b0, 1'b0);
        cmp("after rst drop", 64'(drop_cnt), 64'd0);
        tick();
        drive(1, 8'h31, 32'h00000044, 1);
        tick();
        found = 1'b0;
        expect_frame("post rst", 8'h31, 8'd0, 32'h00000044);

`ifdef NONCE_RESULT_CHECKSUM_EN
        do_reset();
        drive(1, 8'h00, 32'h00000001, 1);
        tick();
        found = 1'b0;
        expect_frame("chk frame", 8'h00, 8'd0, 32'h00000001);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
